// File: rtl/proc_param_pkg.sv
// Shared encodings for the parametrised multicycle processor.
package proc_param_pkg;

   // Instruction opcodes, IR[IW-1:IW-3]
   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   // Instruction step counter
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

   // Shared bus source select
   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_DIN  = 3'd1,
      BUS_RY   = 3'd2,
      BUS_RX   = 3'd3,
      BUS_G    = 3'd4
   } bus_sel_t;

endpackage

// File: rtl/proc_param_regn.sv
// DATA_W-wide register with load enable and asynchronous active-high clear.
module regn #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   // Load on enable, clear asynchronously
   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         o_q <= '0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/proc_param.sv
// Parametrised multicycle processor: shared bus, register file, A/G ALU path,
// Run/Done handshake with a four-step instruction sequencer.
module proc_param
   import proc_param_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires
);

   localparam int unsigned RADDR_W = $clog2(NREGS);
   localparam int unsigned IW      = 3 + 2*RADDR_W;

   step_t               r_step;
   logic [IW-1:0]       r_ir;
   logic                r_z;

   logic [2:0]          w_op;
   logic [RADDR_W-1:0]  w_rx;
   logic [RADDR_W-1:0]  w_ry;
   bus_sel_t            w_sel;
   logic [NREGS-1:0]    w_rin;
   logic                w_ain;
   logic                w_gin;
   logic                w_done;
   logic [DATA_W-1:0]   w_r [NREGS];
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_g;
   logic [DATA_W-1:0]   w_bus;
   logic [DATA_W-1:0]   w_alu;
   logic                w_lt;

   assign w_op = r_ir[IW-1:IW-3];
   assign w_rx = r_ir[IW-4:RADDR_W];
   assign w_ry = r_ir[RADDR_W-1:0];

   // Per-step control decode: bus source, register enables and Done
   always_comb begin
      w_sel  = BUS_NONE;
      w_rin  = '0;
      w_ain  = 1'b0;
      w_gin  = 1'b0;
      w_done = 1'b0;
      case (r_step)
         T1: begin
            case (w_op)
               OP_MV: begin
                  w_sel       = BUS_RY;
                  w_rin[w_rx] = 1'b1;
                  w_done      = 1'b1;
               end
               OP_MVI: begin
                  w_sel       = BUS_DIN;
                  w_rin[w_rx] = 1'b1;
                  w_done      = 1'b1;
               end
               OP_MVNZ: begin
                  w_sel       = BUS_RY;
                  w_rin[w_rx] = ~r_z;
                  w_done      = 1'b1;
               end
               default: begin
                  w_sel = BUS_RX;
                  w_ain = 1'b1;
               end
            endcase
         end
         T2: begin
            w_sel = BUS_RY;
            w_gin = 1'b1;
         end
         T3: begin
            w_sel       = BUS_G;
            w_rin[w_rx] = 1'b1;
            w_done      = 1'b1;
         end
         default: begin
            w_sel = BUS_NONE;
         end
      endcase
   end

   // Single shared bus multiplexer, zero when idle
   always_comb begin
      w_bus = '0;
      case (w_sel)
         BUS_DIN: w_bus = DIN;
         BUS_RY:  w_bus = w_r[w_ry];
         BUS_RX:  w_bus = w_r[w_rx];
         BUS_G:   w_bus = w_g;
         default: w_bus = '0;
      endcase
   end

   assign w_lt = $signed(w_a) < $signed(w_bus);

   // ALU: A op bus
   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD:  w_alu = w_a + w_bus;
         OP_SUB:  w_alu = w_a - w_bus;
         OP_AND:  w_alu = w_a & w_bus;
         OP_OR:   w_alu = w_a | w_bus;
         OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, w_lt};
         default: w_alu = '0;
      endcase
   end

   // Step sequencer, instruction register and zero flag
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_step <= T0;
         r_ir   <= '0;
         r_z    <= 1'b1;
      end else begin
         case (r_step)
            T0: begin
               if (Run) begin
                  r_ir   <= DIN[IW-1:0];
                  r_step <= T1;
               end
            end
            T1:      r_step <= w_done ? T0 : T2;
            T2:      r_step <= T3;
            T3:      r_step <= T0;
            default: r_step <= T0;
         endcase
         if (w_gin) begin
            r_z <= (w_alu == '0);
         end
      end
   end

   // General registers R0..R(NREGS-1)
   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      regn #(.DATA_W(DATA_W)) u_r (
         .i_clk (Clock),
         .i_clr (Reset),
         .i_en  (w_rin[i]),
         .i_d   (w_bus),
         .o_q   (w_r[i])
      );
   end

   // ALU operand latch
   regn #(.DATA_W(DATA_W)) u_a (
      .i_clk (Clock),
      .i_clr (Reset),
      .i_en  (w_ain),
      .i_d   (w_bus),
      .o_q   (w_a)
   );

   // ALU result latch
   regn #(.DATA_W(DATA_W)) u_g (
      .i_clk (Clock),
      .i_clr (Reset),
      .i_en  (w_gin),
      .i_d   (w_alu),
      .o_q   (w_g)
   );

   assign Done     = w_done;
   assign BusWires = w_bus;

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param at default parameters (DATA_W=16, NREGS=8).
module tb_proc_param;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Run;
   logic [15:0] DIN;
   logic        Done;
   logic [15:0] BusWires;

   int total = 0;
   int bad   = 0;

   // Architectural reference state
   logic [15:0] m_r [8];
   logic        m_z;

   proc_param dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .BusWires (BusWires)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step_check(input string tag, input logic [15:0] exp_bus, input logic exp_done);
      #1;
      chk({tag, ".bus"}, BusWires, exp_bus);
      chk({tag, ".done"}, {15'b0, Done}, {15'b0, exp_done});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
      m_z = 1'b1;
   endtask

   // Called at a negedge with the DUT in T0; returns at a negedge back in T0.
   task automatic exec(input logic [8:0] ins, input logic [15:0] imm, input logic run_hold);
      logic [2:0]  op;
      int          rx;
      int          ry;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      op = ins[8:6];
      rx = int'(ins[5:3]);
      ry = int'(ins[2:0]);
      DIN = {7'b0, ins};
      Run = 1'b1;
      step_check("t0", 16'h0000, 1'b0);
      @(negedge Clock);
      Run = run_hold;
      case (op)
         3'b000: begin
            DIN = 16'($urandom);
            step_check("mv.t1", m_r[ry], 1'b1);
            m_r[rx] = m_r[ry];
         end
         3'b001: begin
            DIN = imm;
            step_check("mvi.t1", imm, 1'b1);
            m_r[rx] = imm;
         end
         3'b111: begin
            DIN = 16'($urandom);
            step_check("mvnz.t1", m_r[ry], 1'b1);
            if (!m_z) m_r[rx] = m_r[ry];
         end
         default: begin
            a = m_r[rx];
            b = m_r[ry];
            case (op)
               3'b010:  res = a + b;
               3'b011:  res = a - b;
               3'b100:  res = a & b;
               3'b101:  res = a | b;
               default: res = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
            endcase
            DIN = 16'($urandom);
            step_check("alu.t1", a, 1'b0);
            @(negedge Clock);
            DIN = 16'($urandom);
            step_check("alu.t2", b, 1'b0);
            @(negedge Clock);
            step_check("alu.t3", res, 1'b1);
            m_r[rx] = res;
            m_z = (res == 16'h0000);
         end
      endcase
      @(negedge Clock);
   endtask

   task automatic idle(input int n);
      Run = 1'b0;
      for (int i = 0; i < n; i++) begin
         DIN = 16'($urandom);
         step_check("idle", 16'h0000, 1'b0);
         @(negedge Clock);
      end
   endtask

   // Read a register through the bus using the no-op mv Rn,Rn
   task automatic read_reg(input int n);
      logic [2:0] r;
      r = 3'(n);
      exec({3'b000, r, r}, 16'h0000, 1'b0);
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = 16'h0000;
      model_reset();
      repeat (2) @(negedge Clock);
      step_check("rst.hold", 16'h0000, 1'b0);
      Reset = 1'b0;
      @(negedge Clock);
      idle(2);

      // Abort an add in T2 with an asynchronous reset
      exec(9'h049, 16'h0007, 1'b0);            // mvi R1,#7
      DIN = 16'h0081; Run = 1'b1;              // add R0,R1
      step_check("abort.t0", 16'h0000, 1'b0);
      @(negedge Clock);
      Run = 1'b0;
      step_check("abort.t1", m_r[0], 1'b0);
      @(negedge Clock);
      step_check("abort.t2", m_r[1], 1'b0);
      #2 Reset = 1'b1;
      step_check("abort.rst", 16'h0000, 1'b0);
      model_reset();
      @(negedge Clock);
      step_check("abort.rst2", 16'h0000, 1'b0);
      Reset = 1'b0;
      idle(3);
      for (int i = 0; i < 8; i++) read_reg(i);

      // Z=1 after reset blocks mvnz
      exec(9'h048, 16'h0009, 1'b1);            // mvi R1,#9
      exec(9'h1D1, 16'h0000, 1'b1);            // mvnz R2,R1
      read_reg(2);

      // Directed arithmetic sequence
      exec(9'h040, 16'h0005, 1'b1);            // mvi R0,#5
      exec(9'h048, 16'h0003, 1'b1);            // mvi R1,#3
      exec(9'h081, 16'h0000, 1'b1);            // add R0,R1 -> 8
      exec(9'h0C8, 16'h0000, 1'b1);            // sub R1,R0 -> FFFB
      read_reg(1);
      exec(9'h188, 16'h0000, 1'b1);            // slt R1,R0 -> 1
      read_reg(1);
      exec(9'h0DB, 16'h0000, 1'b1);            // sub R3,R3 -> 0, Z=1
      exec(9'h1D0, 16'h0000, 1'b1);            // mvnz R2,R0 (no write)
      read_reg(2);
      exec(9'h081, 16'h0000, 1'b1);            // add R0,R1 -> 9, Z=0
      exec(9'h1D0, 16'h0000, 1'b1);            // mvnz R2,R0 (writes)
      read_reg(2);
      exec(9'h12D, 16'h0000, 1'b1);            // and R5,R5
      exec(9'h170, 16'h0000, 1'b1);            // or R6,R0

      // Randomized instruction stream with occasional idle gaps
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
         exec(9'($urandom), 16'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 8; i++) read_reg(i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
- Parametrised multicycle processor; next generation of the board-level `proc` core.
- Generalises data width and register-file depth.
- Extends the instruction set with `and`, `or`, `slt` and a conditional move.
- Sits under the board top level: DIN from switches, Run from a switch, BusWires and Done to LEDs.
- Same Run/Done instruction handshake; single shared bus between register file, A, G and DIN.

Parameters:
- DATA_W, 16, data/bus width in bits. Must satisfy DATA_W >= IW.
- NREGS, 8, number of general registers R0..R(NREGS-1). Power of two, 2..16.
- RADDR_W, clog2(NREGS), register address width. Derived; not overridable.
- IW, 3+2*RADDR_W, instruction width taken from DIN[IW-1:0]. Derived.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DIN  input  DATA_W  instruction word in step T0; immediate operand in T1 for `mvi`.
- Run  input  1  start request; sampled only in T0.
- Done  output  1  high during the final step of an instruction (combinational from step and IR).
- BusWires  output  DATA_W  current shared-bus value.

Behaviour:
- Instruction format: IR[IW-1:IW-3]=opcode, IR[IW-4:RADDR_W]=RX, IR[RADDR_W-1:0]=RY.
- Opcodes: 000 `mv`, 001 `mvi`, 010 `add`, 011 `sub`, 100 `and`, 101 `or`, 110 `slt`, 111 `mvnz`.
- Step counter: T0, T1, T2, T3. Returns to T0 on any step where Done=1.
- T0: IR <= DIN[IW-1:0] when Run=1, then go to T1. If Run=0, stay in T0 with IR unchanged. Bus=0, Done=0.
- `mv` T1: bus=RY, RX<=bus, Done=1.
- `mvi` T1: bus=DIN, RX<=bus, Done=1.
- `mvnz` T1: bus=RY; RX<=bus only if Z=0; Done=1 regardless.
- ALU ops T1: bus=RX, A<=bus.
- ALU ops T2: bus=RY, G<=f(A,bus), Z<=(f(A,bus)==0).
- ALU ops T3: bus=G, RX<=bus, Done=1. Latency = 4 cycles including T0.
- ALU function f:
  - `add`/`sub`: modulo 2^DATA_W; no carry or overflow kept.
  - `and`/`or`: bitwise.
  - `slt`: 1 if A < RY as signed two's complement, else 0 (zero-extended to DATA_W).
- Bus default when no source is selected is 0. Exactly one bus source per step.
- Run is ignored in T1..T3. With Run held high, a new T0 fetch follows the Done step with no idle cycle.
- RX==RY is legal:
  - `mv Rn,Rn` is a no-op write.
  - `sub Rn,Rn` gives 0 and sets Z=1.
- Reset (asynchronous, any step including mid-instruction):
  - step=T0, IR=0, A=0, G=0, Z=1, all Rn=0.
  - Done=0 and BusWires=0 while Reset is high.
  - Partial instruction is abandoned; no register write.
- First fetch after reset release is on the first rising edge with Run=1.

Decomposition:
- Package `proc_param_pkg`: opcode constants (`OP_MV`..`OP_MVNZ`), step encoding (T0..T3), bus-select encoding.
- Sub-module `regn`: DATA_W-wide register with enable and asynchronous active-high clear. Instantiated for R0..R(NREGS-1), A and G.
- ALU and step FSM stay inline in proc_param.

Test Plan:
All values for defaults DATA_W=16, NREGS=8, IW=9, format III_XXX_YYY.
1. Reset: assert Reset in T2 of `add` -> Done=0 and BusWires=0 immediately; after release all Rn=0, next fetch starts at T0.
2. `mvi R0,#5`: DIN=0x040 with Run=1, then DIN=0x0005 -> T1 BusWires=0x0005, Done=1, R0=0x0005.
3. `mvi R1,#3` (0x048), then `add R0,R1` (0x081) -> T3 BusWires=0x0008, Done=1 only in T3, R0=0x0008.
4. `sub R1,R0` (0x0C8) with R1=3, R0=8 -> R1=0xFFFB, Z=0.
5. `slt R1,R0` (0x188) with R1=0xFFFB, R0=8 -> R1=0x0001 (signed compare).
6. `sub R3,R3` (0x0DB) sets Z=1; then `mvnz R2,R0` (0x1D0) -> T1 Done=1, R2 unchanged. After a nonzero ALU result (Z=0), repeating it sets R2=R0. Run held high throughout gives back-to-back fetches with no gap.
